// File: rtl/tm1638_frame_sequencer.sv
// Frame-level command sequencer for the TM1638 LED&KEY board: turns one accepted
// display frame into the data-mode, address+data and display-control transactions.
module tm1638_frame_sequencer #(
  parameter int POWER_UP_CYCLES = 50_000_000,
  parameter int OUT_BYTES       = 17,
  parameter int AWAIT_TIMEOUT   = 1_000_000
) (
  input  logic                           CLOCK_50,
  input  logic                           reset,
  input  logic                           frame_valid,
  output logic                           frame_ready,
  input  logic [15:0][7:0]               frame_data,
  input  logic [2:0]                     brightness,
  input  logic                           display_on,
  input  logic                           busy,
  output logic                           activate,
  output logic                           in_cs,
  output logic [OUT_BYTES-1:0][7:0]      out_data,
  output logic [$clog2(OUT_BYTES+1)-1:0] out_count,
  output logic [15:0]                    frames_sent,
  output logic                           timeout_err
);

  localparam int CW = $clog2(OUT_BYTES + 1);
  localparam int PW = (POWER_UP_CYCLES > 0) ? $clog2(POWER_UP_CYCLES + 1) : 1;
  localparam int TW = (AWAIT_TIMEOUT > 0) ? $clog2(AWAIT_TIMEOUT + 1) : 1;
  localparam int NB = 17;

  typedef enum logic [2:0] {
    ST_POWER_UP = 3'd0,
    ST_IDLE     = 3'd1,
    ST_CMD_MODE = 3'd2,
    ST_CMD_DATA = 3'd3,
    ST_CMD_CTRL = 3'd4,
    ST_SEND     = 3'd5,
    ST_AWAIT    = 3'd6
  } state_t;

  function automatic logic [7:0] ctrl_byte(input logic on, input logic [2:0] level);
    logic [7:0] b;
    if (on) begin
      b = {5'b10001, level};
    end else begin
      b = 8'h80;
    end
    return b;
  endfunction

  state_t                    state_q, state_d;
  state_t                    ret_q, ret_d;
  logic [PW-1:0]             pu_cnt_q, pu_cnt_d;
  logic [TW-1:0]             to_cnt_q, to_cnt_d;
  logic                      busy_seen_q, busy_seen_d;
  logic [15:0][7:0]          shadow_q, shadow_d;
  logic [2:0]                bright_q, bright_d;
  logic                      disp_on_q, disp_on_d;
  logic [NB-1:0][7:0]        nxt_data_q, nxt_data_d;
  logic [CW-1:0]             nxt_count_q, nxt_count_d;
  logic                      activate_q, activate_d;
  logic                      in_cs_q, in_cs_d;
  logic [OUT_BYTES-1:0][7:0] out_data_q, out_data_d;
  logic [CW-1:0]             out_count_q, out_count_d;
  logic [15:0]               frames_q, frames_d;
  logic                      timeout_q, timeout_d;

  // Next-state and output decode; every command step funnels through SEND/AWAIT.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    pu_cnt_d    = pu_cnt_q;
    to_cnt_d    = to_cnt_q;
    busy_seen_d = busy_seen_q;
    shadow_d    = shadow_q;
    bright_d    = bright_q;
    disp_on_d   = disp_on_q;
    nxt_data_d  = nxt_data_q;
    nxt_count_d = nxt_count_q;
    activate_d  = activate_q;
    in_cs_d     = in_cs_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    frames_d    = frames_q;
    timeout_d   = timeout_q;

    case (state_q)
      ST_POWER_UP: begin
        if (pu_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          pu_cnt_d = pu_cnt_q - PW'(1);
        end
      end
      ST_IDLE: begin
        if (frame_valid) begin
          shadow_d  = frame_data;
          bright_d  = brightness;
          disp_on_d = display_on;
          state_d   = ST_CMD_MODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD_MODE: begin
        nxt_data_d    = '0;
        nxt_data_d[0] = 8'h40;
        nxt_count_d   = CW'(1);
        ret_d         = ST_CMD_DATA;
        state_d       = ST_SEND;
      end
      ST_CMD_DATA: begin
        nxt_data_d[0] = 8'hC0;
        for (int i = 0; i < 16; i++) begin
          nxt_data_d[i+1] = shadow_q[i];
        end
        nxt_count_d = CW'(NB);
        ret_d       = ST_CMD_CTRL;
        state_d     = ST_SEND;
      end
      ST_CMD_CTRL: begin
        nxt_data_d    = '0;
        nxt_data_d[0] = ctrl_byte(disp_on_q, bright_q);
        nxt_count_d   = CW'(1);
        ret_d         = ST_IDLE;
        state_d       = ST_SEND;
      end
      ST_SEND: begin
        if (!busy) begin
          out_data_d = '0;
          for (int i = 0; i < NB; i++) begin
            if (CW'(i) < nxt_count_q) begin
              out_data_d[i] = nxt_data_q[i];
            end else begin
              out_data_d[i] = 8'h00;
            end
          end
          out_count_d = nxt_count_q;
          in_cs_d     = 1'b1;
          activate_d  = 1'b1;
          busy_seen_d = 1'b0;
          to_cnt_d    = '0;
          state_d     = ST_AWAIT;
        end else begin
          activate_d = 1'b0;
        end
      end
      ST_AWAIT: begin
        // A busy rise wins over a timeout expiring in the same cycle.
        if (busy && !busy_seen_q) begin
          busy_seen_d = 1'b1;
          activate_d  = 1'b0;
        end else if (!busy && busy_seen_q) begin
          state_d = ret_q;
          if (ret_q == ST_IDLE) begin
            frames_d = frames_q + 16'd1;
            in_cs_d  = 1'b0;
          end else begin
            in_cs_d = in_cs_q;
          end
        end else if (!busy_seen_q) begin
          to_cnt_d = to_cnt_q + TW'(1);
          if ((to_cnt_q + TW'(1)) == TW'(AWAIT_TIMEOUT)) begin
            timeout_d  = 1'b1;
            activate_d = 1'b0;
            in_cs_d    = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_AWAIT;
          end
        end else begin
          state_d = ST_AWAIT;
        end
      end
      default: begin
        state_d = ST_POWER_UP;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q     <= ST_POWER_UP;
      ret_q       <= ST_IDLE;
      pu_cnt_q    <= PW'(POWER_UP_CYCLES);
      to_cnt_q    <= '0;
      busy_seen_q <= 1'b0;
      shadow_q    <= '0;
      bright_q    <= 3'd0;
      disp_on_q   <= 1'b0;
      nxt_data_q  <= '0;
      nxt_count_q <= '0;
      activate_q  <= 1'b0;
      in_cs_q     <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      frames_q    <= 16'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      pu_cnt_q    <= pu_cnt_d;
      to_cnt_q    <= to_cnt_d;
      busy_seen_q <= busy_seen_d;
      shadow_q    <= shadow_d;
      bright_q    <= bright_d;
      disp_on_q   <= disp_on_d;
      nxt_data_q  <= nxt_data_d;
      nxt_count_q <= nxt_count_d;
      activate_q  <= activate_d;
      in_cs_q     <= in_cs_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      frames_q    <= frames_d;
      timeout_q   <= timeout_d;
    end
  end

  assign frame_ready = (state_q == ST_IDLE);
  assign activate    = activate_q;
  assign in_cs       = in_cs_q;
  assign out_data    = out_data_q;
  assign out_count   = out_count_q;
  assign frames_sent = frames_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_tm1638_frame_sequencer.sv
// Directed + randomized bench: an SPI-controller model records each transaction and
// a frame-level reference model supplies the expected byte stream.
module tb_tm1638_frame_sequencer;

  localparam int PU = 10;
  localparam int OB = 17;
  localparam int TO = 20;

  logic                 CLOCK_50;
  logic                 reset;
  logic                 frame_valid;
  logic                 frame_ready;
  logic [15:0][7:0]     frame_data;
  logic [2:0]           brightness;
  logic                 display_on;
  logic                 busy;
  logic                 activate;
  logic                 in_cs;
  logic [OB-1:0][7:0]   out_data;
  logic [4:0]           out_count;
  logic [15:0]          frames_sent;
  logic                 timeout_err;

  tm1638_frame_sequencer #(
    .POWER_UP_CYCLES(PU),
    .OUT_BYTES      (OB),
    .AWAIT_TIMEOUT  (TO)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_data (frame_data),
    .brightness (brightness),
    .display_on (display_on),
    .busy       (busy),
    .activate   (activate),
    .in_cs      (in_cs),
    .out_data   (out_data),
    .out_count  (out_count),
    .frames_sent(frames_sent),
    .timeout_err(timeout_err)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  int total = 0;
  int bad   = 0;

  bit ctl_en     = 1'b0;
  bit force_busy = 1'b0;
  int bcnt       = 0;
  bit pend       = 1'b0;
  int cs_bad     = 0;
  int pad_bad    = 0;

  int         rec_cnt[$];
  logic [7:0] rec_bytes[$];
  int         exp_cnt[$];
  logic [7:0] exp_bytes[$];
  int         exp_frames = 0;

  // SPI controller model: busy rises one cycle after activate and stays high 40 cycles.
  initial begin
    busy = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      if (force_busy) begin
        busy = 1'b1;
      end else if (!ctl_en) begin
        busy = 1'b0;
      end else if (bcnt > 0) begin
        bcnt--;
        busy = (bcnt != 0);
      end else if (pend) begin
        pend = 1'b0;
        busy = 1'b1;
        bcnt = 40;
      end else begin
        busy = 1'b0;
        if (activate === 1'b1) begin
          rec_cnt.push_back(int'(out_count));
          for (int i = 0; i < OB; i++) begin
            if (i < int'(out_count)) rec_bytes.push_back(out_data[i]);
            else if (out_data[i] !== 8'h00) pad_bad++;
          end
          if (in_cs !== 1'b1) cs_bad++;
          pend = 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_ready(input string tag, input int bound);
    int n;
    n = 0;
    while (frame_ready !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    check(tag, {31'd0, frame_ready}, 32'd1);
  endtask

  task automatic power_up(input string tag);
    int n;
    bit noisy;
    n = 0;
    noisy = 1'b0;
    @(negedge CLOCK_50);
    reset = 1'b1;
    while (frame_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
      if (activate !== 1'b0 || out_count !== 5'd0) noisy = 1'b1;
    end
    check({tag, "_edges"}, 32'(n), 32'(PU + 1));
    check({tag, "_quiet"}, {31'd0, noisy}, 32'd0);
  endtask

  // Frame-level reference: three transactions derived directly from the frame contents.
  task automatic offer_frame(input logic [15:0][7:0] d, input logic [2:0] b,
                             input logic on, input bit meas);
    int lat;
    exp_cnt.push_back(1);
    exp_bytes.push_back(8'h40);
    exp_cnt.push_back(17);
    exp_bytes.push_back(8'hC0);
    for (int i = 0; i < 16; i++) exp_bytes.push_back(d[i]);
    exp_cnt.push_back(1);
    exp_bytes.push_back(on ? 8'(136 + int'(b)) : 8'd128);
    @(negedge CLOCK_50);
    frame_data  = d;
    brightness  = b;
    display_on  = on;
    frame_valid = 1'b1;
    tick();
    check("accept_drop", {31'd0, frame_ready}, 32'd0);
    frame_valid = 1'b0;
    frame_data  = {$urandom, $urandom, $urandom, $urandom};
    brightness  = ~b;
    display_on  = ~on;
    if (meas) begin
      lat = 1;
      while (activate !== 1'b1 && lat < 10) begin
        tick();
        lat++;
      end
      check("accept_latency", 32'(lat), 32'd3);
    end
  endtask

  task automatic compare_frame(input string tag);
    int nb;
    check({tag, "_ntx"}, 32'(rec_cnt.size()), 32'(exp_cnt.size()));
    for (int t = 0; t < rec_cnt.size() && t < exp_cnt.size(); t++)
      check($sformatf("%s_count%0d", tag, t), 32'(rec_cnt[t]), 32'(exp_cnt[t]));
    check({tag, "_nbytes"}, 32'(rec_bytes.size()), 32'(exp_bytes.size()));
    nb = (rec_bytes.size() < exp_bytes.size()) ? rec_bytes.size() : exp_bytes.size();
    for (int i = 0; i < nb; i++)
      check($sformatf("%s_byte%0d", tag, i), {24'd0, rec_bytes[i]}, {24'd0, exp_bytes[i]});
    check({tag, "_pad"}, 32'(pad_bad), 32'd0);
    check({tag, "_cs"}, 32'(cs_bad), 32'd0);
    rec_cnt.delete();
    rec_bytes.delete();
    exp_cnt.delete();
    exp_bytes.delete();
  endtask

  task automatic finish_frame(input string tag);
    wait_ready({tag, "_done"}, 3000);
    exp_frames++;
    check({tag, "_frames"}, {16'd0, frames_sent}, 32'(exp_frames));
    compare_frame(tag);
  endtask

  initial begin
    logic [15:0][7:0] d;
    int n;
    int hi;
    bit act_seen;

    reset       = 1'b0;
    frame_valid = 1'b0;
    frame_data  = '0;
    brightness  = 3'd0;
    display_on  = 1'b0;

    repeat (2) @(posedge CLOCK_50);
    #1;
    check("rst_ready", {31'd0, frame_ready}, 32'd0);
    check("rst_activate", {31'd0, activate}, 32'd0);
    check("rst_in_cs", {31'd0, in_cs}, 32'd0);
    check("rst_out_count", {27'd0, out_count}, 32'd0);
    check("rst_out_data", {31'd0, |out_data}, 32'd0);
    check("rst_frames", {16'd0, frames_sent}, 32'd0);
    check("rst_timeout", {31'd0, timeout_err}, 32'd0);
    power_up("pu1");

    // Directed full frame: bytes 1..16, brightness 7, display on.
    ctl_en = 1'b1;
    for (int i = 0; i < 16; i++) d[i] = 8'(i + 1);
    offer_frame(d, 3'd7, 1'b1, 1'b1);
    finish_frame("full");
    check("full_timeout", {31'd0, timeout_err}, 32'd0);

    for (int r = 0; r < 3; r++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      offer_frame(d, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
      finish_frame($sformatf("rand%0d", r));
    end

    // Busy already high when the frame is accepted.
    force_busy = 1'b1;
    repeat (2) tick();
    d = {$urandom, $urandom, $urandom, $urandom};
    offer_frame(d, 3'd2, 1'b1, 1'b0);
    act_seen = 1'b0;
    repeat (100) begin
      tick();
      if (activate !== 1'b0) act_seen = 1'b1;
    end
    check("busyhold_no_act", {31'd0, act_seen}, 32'd0);
    check("busyhold_no_tx", 32'(rec_cnt.size()), 32'd0);
    force_busy = 1'b0;
    finish_frame("busyhold");

    // Display off plus a second frame_valid pulse while transmitting.
    d = {$urandom, $urandom, $urandom, $urandom};
    offer_frame(d, 3'd5, 1'b0, 1'b0);
    repeat (20) tick();
    @(negedge CLOCK_50);
    frame_valid = 1'b1;
    tick();
    check("bp_not_ready", {31'd0, frame_ready}, 32'd0);
    frame_valid = 1'b0;
    finish_frame("dispoff");
    repeat (30) tick();
    check("bp_frames_hold", {16'd0, frames_sent}, 32'(exp_frames));
    check("bp_no_extra_tx", 32'(rec_cnt.size()), 32'd0);

    // Reset during the address+data transaction.
    d = {$urandom, $urandom, $urandom, $urandom};
    offer_frame(d, 3'd1, 1'b1, 1'b0);
    n = 0;
    while (!(rec_cnt.size() == 2 && busy === 1'b1) && n < 500) begin
      tick();
      n++;
    end
    check("rmf_reach", {31'd0, (n < 500)}, 32'd1);
    @(negedge CLOCK_50);
    reset = 1'b0;
    tick();
    check("rmf_activate", {31'd0, activate}, 32'd0);
    check("rmf_in_cs", {31'd0, in_cs}, 32'd0);
    check("rmf_out_data", {31'd0, |out_data}, 32'd0);
    check("rmf_out_count", {27'd0, out_count}, 32'd0);
    check("rmf_frames", {16'd0, frames_sent}, 32'd0);
    check("rmf_ready", {31'd0, frame_ready}, 32'd0);
    power_up("pu2");
    exp_frames = 0;
    rec_cnt.delete();
    rec_bytes.delete();
    exp_cnt.delete();
    exp_bytes.delete();
    repeat (60) tick();

    // Await timeout: controller never raises busy.
    ctl_en = 1'b0;
    repeat (2) tick();
    d = {$urandom, $urandom, $urandom, $urandom};
    offer_frame(d, 3'd3, 1'b1, 1'b0);
    n = 0;
    while (activate !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    hi = 0;
    while (activate === 1'b1 && hi < 100) begin
      hi++;
      tick();
    end
    check("to_act_width", 32'(hi), 32'(TO));
    check("to_err", {31'd0, timeout_err}, 32'd1);
    check("to_ready", {31'd0, frame_ready}, 32'd1);
    check("to_frames", {16'd0, frames_sent}, 32'd0);
    check("to_out_count", {27'd0, out_count}, 32'd1);
    check("to_out_byte0", {24'd0, out_data[0]}, 32'h40);
    check("to_no_tx", 32'(rec_cnt.size()), 32'd0);
    exp_cnt.delete();
    exp_bytes.delete();

    // Recovery after timeout; the error flag stays set.
    ctl_en = 1'b1;
    repeat (2) tick();
    d = {$urandom, $urandom, $urandom, $urandom};
    offer_frame(d, 3'($urandom_range(0, 7)), 1'b1, 1'b1);
    finish_frame("recover");
    check("recover_sticky", {31'd0, timeout_err}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tm1638_frame_sequencer.md
# tm1638_frame_sequencer

Upstream command sequencer for the TM1638 LED&KEY board. It accepts a 16-byte display-RAM frame plus brightness over a valid/ready handshake. It emits the three TM1638 transactions (data-mode, address+data, display-control) through the busy/activate interface of the SPI byte controller that drives the GPIO pins. This block replaces ad-hoc top-level command state machines and keeps the send/await subroutine in one place.

## Interface
- POWER_UP_CYCLES, 50_000_000: CLOCK_50 cycles to wait after reset before the first transaction.
- OUT_BYTES, 17: depth of out_data; must be ≥ 17.
- AWAIT_TIMEOUT, 1_000_000: cycles to wait for busy to rise after activate before the transaction is abandoned.
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  reset, synchronous, active-low; clock CLOCK_50.
- frame_valid  in  1  frame offered.
- frame_ready  out  1  frame accepted when frame_valid && frame_ready at posedge.
- frame_data  in  16×8  display RAM bytes; index i goes to TM1638 address i.
- brightness  in  3  pulse-width setting 0..7.
- display_on  in  1  1 = display enabled.
- busy  in  1  SPI controller busy.
- activate  out  1  start-transaction request to the SPI controller.
- in_cs  out  1  chip-select enable to the SPI controller (single chip).
- out_data  out  OUT_BYTES×8  bytes to shift, index 0 first.
- out_count  out  $clog2(OUT_BYTES+1)  number of valid bytes.
- frames_sent  out  16  count of completed frames, wraps at 0xFFFF→0.
- timeout_err  out  1  sticky; set on any await timeout.

## Operation
- States: POWER_UP, IDLE, CMD_MODE, CMD_DATA, CMD_CTRL, SEND, AWAIT.
- POWER_UP: the counter loads POWER_UP_CYCLES at reset and decrements each cycle. When it reads 0, the block moves to IDLE.
- IDLE: frame_ready = (state==IDLE), a decode of the registered state. On acceptance the block latches frame_data, brightness and display_on into shadow registers and moves to CMD_MODE. Inputs are ignored outside IDLE.
- CMD_MODE: next bytes = {0x40}, count 1. Go to SEND, then return to CMD_DATA.
- CMD_DATA: next bytes = {0xC0, shadow[0..15]}, count 17. Go to SEND, then return to CMD_CTRL.
- CMD_CTRL: next byte = display_on ? (0x88 | brightness) : 0x80, count 1. Go to SEND, then return to IDLE. frames_sent increments by 1 on the return.
- SEND:
  - While busy=1, hold activate=0 and wait.
  - When busy=0, copy the next bytes to out_data. Bytes at index ≥ count are zero. Set out_count, in_cs=1, activate=1, clear busy_seen and the timeout counter, and go to AWAIT.
- AWAIT:
  - busy=1 and !busy_seen: set busy_seen=1 and activate=0.
  - busy=0 and busy_seen: go to the return state.
  - !busy_seen: the timeout counter increments. When it reaches AWAIT_TIMEOUT, the block sets timeout_err, sets activate=0, abandons the rest of the frame, goes to IDLE, and does not increment frames_sent.
- out_data and out_count change only in SEND when busy=0. They are stable from then until the next SEND.
- Reset, applied at any time including mid-transaction, forces the following on the next edge:
  - state POWER_UP and counter = POWER_UP_CYCLES;
  - activate=0, in_cs=0, out_count=0, out_data all 0x00;
  - shadow registers 0, frames_sent=0, timeout_err=0.
  - frame_ready is 0 during reset because the state is POWER_UP.

## Timing
- Reset release to IDLE: POWER_UP_CYCLES+1 edges; frame_ready goes high in that cycle.
- Acceptance to the first activate=1 when busy=0: 3 cycles (IDLE→CMD_MODE→SEND→activate registered).
- Each command step costs 1 cycle in CMD_x, ≥1 cycle in SEND, and ≥2 cycles in AWAIT.
- activate stays high from the SEND exit until the first cycle busy is seen high. The SPI controller must see it for at least one edge.
- frame_ready drops on the cycle after acceptance. It is next high the cycle after the CMD_CTRL transaction completes, or after a timeout.
- A simultaneous busy rise and timeout expiry is resolved as busy seen: there is no error.

## Test plan
- Power-up: POWER_UP_CYCLES=10, reset low for 2 cycles then high → frame_ready rises exactly 11 edges after release; activate=0 and out_count=0 throughout.
- Full frame: model the controller with busy high for 40 cycles, 1 cycle after activate. Offer frame_data[i]=i+1, brightness=7, display_on=1 → three transactions in order:
  - {0x40}, count 1;
  - {0xC0,0x01..0x10}, count 17;
  - {0x8F}, count 1.
  - Then frames_sent=1 and frame_ready=1.
- Busy held high before SEND: keep busy=1 for 100 cycles when the frame is accepted → activate stays 0 until busy falls, then pulses; the byte sequence is unchanged.
- Timeout: AWAIT_TIMEOUT=20, busy tied 0 → activate is high for 20 cycles then falls; timeout_err=1, state returns to IDLE, frames_sent=0.
- Reset mid-frame: assert reset during the CMD_DATA AWAIT → the next edge gives activate=0, in_cs=0, out_data all 0x00, frames_sent=0; the power-up wait restarts.
- Display off and backpressure: display_on=0, brightness=5 → control byte is 0x80. A second frame_valid pulse during transmission is not accepted (frame_ready=0); only 1 frame is counted.
